uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver feeding the SOC's RXD pin into the memory-mapped I/O path.
- Synchronises RXD, detects start bits, samples 8N1 frames at bit centre, and presents each byte in a one-deep holding register with a valid/ready handshake.
- Reports framing errors and overruns as single-cycle pulses for the SOC status register.

Parameters:
- CLKS_PER_BIT, 104: clock cycles per UART bit (12 MHz / 115200). Must be ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2: cycles from start-bit detection to the start-bit centre sample. Derived; not overridden.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- RXD  input  1  asynchronous serial line, idle high
- rx_data  output  8  received byte, valid while rx_valid=1
- rx_valid  output  1  holding register full
- rx_ready  input  1  consumer accepts byte; takes effect on any cycle where rx_valid=1
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte completed while the holding register was full and not being read

Behaviour:
- Reset (CLK edge with RESET=1):
  - Both synchroniser flops = 1, state = IDLE, counters = 0.
  - rx_data = 8'h00, rx_valid = 0, frame_err = 0, overrun = 0.
  - Reset mid-frame abandons the frame; no partial byte is delivered.
- Synchroniser: two flops on RXD; the FSM uses only the second-flop output (rxs).
- Bit-timing counter cnt: width clog2(CLKS_PER_BIT); cleared on every state change.
- Bit index idx: 3 bits.
- IDLE: on rxs=0 -> START, cnt=0.
- START: count until cnt == HALF_BIT-1, then sample rxs.
  - rxs=0 -> DATA, idx=0.
  - rxs=1 -> IDLE (glitch reject, no flag).
- DATA: count until cnt == CLKS_PER_BIT-1, then sample rxs into shift[idx], LSB first.
  - idx==7 -> STOP; otherwise idx+1.
- STOP: count until cnt == CLKS_PER_BIT-1, then sample rxs.
  - rxs=1 -> deliver byte, -> IDLE.
  - rxs=0 -> frame_err=1 for one cycle, byte discarded, -> BREAK.
- BREAK: wait for rxs=1, then -> IDLE. A continuously low line gives exactly one frame_err, not repeated ones.
- Sample timing, with t = first cycle rxs=0 seen in IDLE:
  - Start centre sampled at t+HALF_BIT.
  - Data bit k sampled at t+HALF_BIT+(k+1)*CLKS_PER_BIT.
  - Stop bit sampled at t+HALF_BIT+9*CLKS_PER_BIT.
  - rx_valid rises on the following cycle.
- Delivery, evaluated on the stop-sample cycle:
  - Holding empty, or (rx_valid=1 and rx_ready=1) the same cycle: rx_data <= byte, rx_valid <= 1.
  - rx_valid=1 and rx_ready=0: byte dropped, rx_data unchanged, overrun=1 for one cycle.
- Handshake:
  - rx_valid=1 and rx_ready=1 with no delivery that cycle: rx_valid <= 0, rx_data holds its last value.
  - rx_ready while rx_valid=0 is ignored.
- frame_err and overrun are never asserted together (a framing error delivers nothing).
- Back-to-back frames: a start bit immediately following the stop-bit centre is accepted. IDLE is re-entered at the stop-bit centre, giving half a bit of margin.

Test Plan (CLKS_PER_BIT=16):
- Reset, RXD idle high for 50 cycles -> rx_valid=0, rx_data=0x00, no flag pulses.
- Frame 0x55 (start, 1,0,1,0,1,0,1,0, stop 1), rx_ready held 0 -> rx_valid rises exactly at t+8+9*16+1, rx_data=0x55. Then pulse rx_ready one cycle -> rx_valid=0 next cycle.
- Back-to-back frames 0xA3 then 0x0F with rx_ready tied 1 -> two deliveries of 0xA3 then 0x0F, no overrun.
- Frames 0x12 then 0x34 with rx_ready=0 -> rx_data stays 0x12, one overrun pulse at the second stop-sample cycle, rx_valid stays 1.
- RXD low for 4 cycles then high (glitch) -> returns to IDLE, no delivery, no frame_err. RXD held low permanently -> exactly one frame_err pulse, no further events; RXD released high then frame 0x7E -> delivered correctly.
- RESET asserted for 1 cycle during data bit 4 of 0xC6 -> outputs return to reset values, no delivery. A following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop RXD synchroniser, bit-centre sampling, one-deep
// holding register with valid/ready handshake, frame-error and overrun pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for a low level on the synchronised RXD
// S_START | counting to the start-bit centre to confirm a real start
// S_DATA  | sampling eight data bits LSB first at each bit centre
// S_STOP  | sampling the stop bit, then delivering or flagging the byte
// S_BREAK | stop bit was low; waiting for the line to return high
module uart_rx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       RXD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync1_d;
   logic          rxs_q, rxs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;

   always_comb begin
      state_d     = state_q;
      sync1_d     = RXD;
      rxs_d       = sync1_q;
      cnt_d       = cnt_q + 1'b1;
      idx_d       = idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rxs_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == HALF_END) begin
               cnt_d = '0;
               if (!rxs_q) begin
                  state_d = S_DATA;
                  idx_d   = 3'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d          = '0;
               shift_d[idx_q] = rxs_q;
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_END) begin
               cnt_d = '0;
               if (rxs_q) begin
                  // Back to idle at the stop centre: half a bit of margin for the next start.
                  state_d = S_IDLE;
                  if (!rx_valid_q || rx_ready) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  state_d     = S_BREAK;
                  frame_err_d = 1'b1;
               end
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rxs_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         rxs_q       <= 1'b1;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         rxs_q       <= rxs_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; expected bytes go into a
// scoreboard queue as frames are sent and are popped when a delivery appears.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       RXD;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int deliveries = 0;
   int ferr_cnt   = 0;
   int ovr_cnt    = 0;
   int last_deliv_cyc = -1;
   int last_ovr_cyc   = -1;
   int start_cyc      = 0;
   logic [7:0] exp_q[$];
   logic prev_valid = 1'b0;
   logic prev_take  = 1'b0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .RXD       (RXD),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Delivery monitor: a new byte is present when valid rises or reappears right after a take.
   always @(negedge CLK) begin
      logic [7:0] e;
      if (rx_valid && (!prev_valid || prev_take)) begin
         deliveries++;
         last_deliv_cyc = cyc;
         chk("deliv_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("deliv_data", rx_data, e);
         end
      end
      if (frame_err) ferr_cnt++;
      if (overrun) begin
         ovr_cnt++;
         last_ovr_cyc = cyc;
      end
      if (frame_err || overrun) chk("ferr_ovr_excl", (frame_err && overrun), 0);
      prev_valid = rx_valid;
      prev_take  = rx_valid && rx_ready;
   end

   // All line tasks enter and leave one time unit after a rising edge.
   task automatic line(input logic b, input int n);
      RXD = b;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      start_cyc = cyc;
      line(1'b0, CPB);
      for (int i = 0; i < 8; i++) line(d[i], CPB);
      line(stop, CPB);
   endtask

   task automatic idle(input int n);
      line(1'b1, n);
   endtask

   int d0, s2;

   initial begin
      RESET = 1'b1;
      RXD = 1'b1;
      rx_ready = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b0;
      idle(50);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_ferr_cnt", ferr_cnt, 0);
      chk("rst_ovr_cnt", ovr_cnt, 0);

      // 0x55 with ready low: exact rise time, then a one-cycle ready pulse
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1);
      idle(10);
      chk("t55_latency", last_deliv_cyc - start_cyc, 8 + 9 * CPB + 3);
      chk("t55_valid", rx_valid, 1);
      chk("t55_data", rx_data, 8'h55);
      rx_ready = 1'b1;
      @(posedge CLK);
      #1;
      rx_ready = 1'b0;
      chk("t55_valid_cleared", rx_valid, 0);
      chk("t55_data_held", rx_data, 8'h55);

      // back-to-back with ready tied high
      d0 = deliveries;
      rx_ready = 1'b1;
      exp_q.push_back(8'hA3);
      exp_q.push_back(8'h0F);
      send_frame(8'hA3, 1'b1);
      send_frame(8'h0F, 1'b1);
      idle(20);
      chk("b2b_count", deliveries - d0, 2);
      chk("b2b_no_ovr", ovr_cnt, 0);
      chk("b2b_q_empty", exp_q.size(), 0);
      chk("b2b_last_data", rx_data, 8'h0F);

      // overrun: second byte dropped while holding is full
      rx_ready = 1'b0;
      d0 = deliveries;
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1);
      s2 = 0;
      send_frame(8'h34, 1'b1);
      s2 = start_cyc;
      idle(20);
      chk("ovr_count", ovr_cnt, 1);
      chk("ovr_timing", last_ovr_cyc - s2, 8 + 9 * CPB + 3);
      chk("ovr_valid", rx_valid, 1);
      chk("ovr_data", rx_data, 8'h12);
      chk("ovr_deliv", deliveries - d0, 1);
      rx_ready = 1'b1;
      @(posedge CLK);
      #1;
      rx_ready = 1'b0;
      chk("ovr_drained", rx_valid, 0);

      // glitch shorter than half a bit
      d0 = deliveries;
      line(1'b0, 4);
      idle(60);
      chk("glitch_no_ferr", ferr_cnt, 0);
      chk("glitch_no_deliv", deliveries - d0, 0);
      chk("glitch_valid", rx_valid, 0);

      // line held low: exactly one frame error
      line(1'b0, 400);
      chk("break_one_ferr", ferr_cnt, 1);
      chk("break_no_deliv", deliveries - d0, 0);
      chk("break_no_ovr", ovr_cnt, 1);
      idle(20);
      rx_ready = 1'b1;
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1);
      idle(20);
      chk("after_break_deliv", deliveries - d0, 1);
      chk("after_break_data", rx_data, 8'h7E);
      chk("after_break_ferr", ferr_cnt, 1);

      // reset during data bit 4 of 0xC6
      rx_ready = 1'b0;
      d0 = deliveries;
      line(1'b0, CPB);
      for (int i = 0; i < 4; i++) line(((8'hC6 >> i) & 8'h01) != 0, CPB);
      line(1'b0, 8);
      RESET = 1'b1;
      RXD = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      chk("midrst_valid", rx_valid, 0);
      chk("midrst_data", rx_data, 8'h00);
      idle(200);
      chk("midrst_no_deliv", deliveries - d0, 0);
      chk("midrst_no_ferr", ferr_cnt, 1);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      idle(20);
      chk("post_rst_deliv", deliveries - d0, 1);
      chk("post_rst_data", rx_data, 8'h81);
      chk("post_rst_valid", rx_valid, 1);
      chk("final_q_empty", exp_q.size(), 0);
      chk("final_ovr", ovr_cnt, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
